ipu: RTL and testbench

Interrupt priority unit sitting directly upstream of the fetch stage. It collects up to `N_SRC` synchronous interrupt request lines, latches rising edges as pending, picks the highest-priority enabled source, and raises a single-cycle `ipu_int` pulse that redirects fetch to the handler at 0x0005. It then tracks the `int_ack` handshake and the in-service period until fetch decodes the return instruction (opcode 0011). Requests are deferred while fetch is redirecting (`jorb`), stalling (`ldStall`) or halted, so fetch's saved return PC is always valid.

---
 rtl/ipu.sv | 157 +++++++++++++++
 tb/tb_ipu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ipu.sv
// ipu -- interrupt priority unit feeding the fetch stage.
//
// Latches rising edges on up to N_SRC request lines as pending, grants the
// lowest-index enabled pending source, and issues a one-cycle ipu_int pulse
// that redirects fetch to the handler. The grant is then tracked through the
// int_ack handshake and the in-service period until fetch decodes the
// return instruction (rti).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   irq[N_SRC]        request lines, rising edge = event
//   irq_en[N_SRC]     per-source grant enable (pending still latches)
//   halt/jorb/ldStall fetch conditions that hold off ipu_int
//   int_ack           fetch's registered copy of ipu_int
//   rti               fetch decoded the return instruction this cycle
//   clr_ovr           clears all overrun flags
//   ipu_int           one-cycle interrupt request to fetch
//   int_id[3]         granted/serviced source index, held until next grant
//   in_service        high from the fire cycle until rti is accepted
//   pending[N_SRC]    latched, not-yet-granted events
//   overrun[N_SRC]    sticky: event arrived while already pending
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing granted; looking for an enabled pending source
// REQ      | winner latched in int_id; ipu_int fires when fetch unblocked
// ACK_WAIT | fired last cycle; expecting int_ack from fetch
// SERVICE  | handler running; waiting for rti

module ipu #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic [N_SRC-1:0] irq_en,
    input  logic             halt,
    input  logic             jorb,
    input  logic             ldStall,
    input  logic             int_ack,
    input  logic             rti,
    input  logic             clr_ovr,
    output logic             ipu_int,
    output logic [2:0]       int_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ACK_WAIT = 2'd2,
        SERVICE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] overrun_q, overrun_d;
    logic [2:0]       int_id_q, int_id_d;
    logic             in_service_q, in_service_d;

    logic [N_SRC-1:0] irq_edge;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] id_sel;
    logic [N_SRC-1:0] clr_pend;
    logic [N_SRC-1:0] retry_set;
    logic [2:0]       win_id;
    logic             fire;

    always_comb begin
        irq_edge = irq & ~irq_q;
        cand     = pending_q & irq_en;
        win_id   = 3'd0;
        // Scan from the top so the lowest index is the last to write.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) win_id = 3'(i);
        end
        for (int i = 0; i < N_SRC; i++) begin
            id_sel[i] = (int_id_q == 3'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        int_id_d     = int_id_q;
        in_service_d = in_service_q;
        clr_pend     = '0;
        retry_set    = '0;
        fire         = 1'b0;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d  = REQ;
                    int_id_d = win_id;
                end
            end
            REQ: begin
                // int_id stays frozen here; later arrivals never pre-empt.
                fire = ~halt & ~jorb & ~ldStall;
                if (fire) begin
                    clr_pend     = id_sel;
                    in_service_d = 1'b1;
                    state_d      = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (int_ack) begin
                    state_d = SERVICE;
                end else begin
                    // Fetch never took the redirect: put the event back and retry.
                    retry_set    = id_sel;
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            SERVICE: begin
                if (rti) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge on the source being cleared keeps it pending.
        pending_d = (pending_q & ~clr_pend) | retry_set | irq_edge;
        overrun_d = clr_ovr ? '0 : overrun_q;
        overrun_d = overrun_d | (irq_edge & pending_q & ~clr_pend);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            int_id_q     <= 3'd0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign ipu_int    = fire;
    assign int_id     = int_id_q;
    assign in_service = in_service_q | fire;
    assign pending    = pending_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ipu.sv
// Directed bench for ipu (N_SRC = 4). A tiny fetch model returns int_ack as
// the registered copy of ipu_int; ack_kill suppresses it.

module tb_ipu;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq, irq_en;
    logic       halt, jorb, ldStall, int_ack, rti, clr_ovr;
    logic       ipu_int, in_service;
    logic [2:0] int_id;
    logic [3:0] pending, overrun;

    logic       ack_q;
    logic       ack_kill;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_pulse = 0;
    int         base;

    always #5 clk = ~clk;

    ipu #(.N_SRC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .irq_en     (irq_en),
        .halt       (halt),
        .jorb       (jorb),
        .ldStall    (ldStall),
        .int_ack    (int_ack),
        .rti        (rti),
        .clr_ovr    (clr_ovr),
        .ipu_int    (ipu_int),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending),
        .overrun    (overrun)
    );

    always_ff @(posedge clk) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= ipu_int;
    end
    assign int_ack = ack_q & ~ack_kill;

    always @(negedge clk) if (ipu_int) n_pulse++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        irq = 4'b0; irq_en = 4'b1111; halt = 0; jorb = 0; ldStall = 0;
        rti = 0; clr_ovr = 0; ack_kill = 0;
        do_reset();
        mid();
        chk("rst_int",  32'(ipu_int), 0);
        chk("rst_id",   32'(int_id), 0);
        chk("rst_insv", 32'(in_service), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_ovr",  32'(overrun), 0);

        // single event on source 0
        base = n_pulse;
        irq = 4'b0001; tick();
        irq = 4'b0000;
        mid(); chk("s_pend1", 32'(pending), 4'b0001);
        chk("s_int_early", 32'(ipu_int), 0);
        tick(); mid();
        chk("s_int", 32'(ipu_int), 1);
        chk("s_id", 32'(int_id), 0);
        tick(); mid();
        chk("s_int_off", 32'(ipu_int), 0);
        chk("s_pend0", 32'(pending), 0);
        chk("s_insv_ack", 32'(in_service), 1);
        tick(); mid();
        chk("s_insv_srv", 32'(in_service), 1);
        rti = 1; tick(); rti = 0; mid();
        chk("s_insv_done", 32'(in_service), 0);
        tick(); tick(); mid();
        chk("s_pulses", 32'(n_pulse - base), 1);

        // priority: sources 3 and 1 together
        base = n_pulse;
        irq = 4'b1010; tick(); irq = 4'b0000;
        tick(); mid();
        chk("p_int1", 32'(ipu_int), 1);
        chk("p_id1", 32'(int_id), 1);
        tick(); mid();
        chk("p_pend", 32'(pending), 4'b1000);
        tick();
        rti = 1; tick(); rti = 0; mid();
        chk("p_idle_gap", 32'(ipu_int), 0);
        tick(); mid();
        chk("p_int2", 32'(ipu_int), 1);
        chk("p_id2", 32'(int_id), 3);
        tick(); tick();
        rti = 1; tick(); rti = 0;
        tick(); tick(); mid();
        chk("p_pulses", 32'(n_pulse - base), 2);
        chk("p_pend_end", 32'(pending), 0);

        // blocking with jorb
        irq = 4'b0100; jorb = 1; tick(); irq = 4'b0000;
        tick(); mid();
        chk("b_blk0", 32'(ipu_int), 0);
        chk("b_id", 32'(int_id), 2);
        tick(); mid(); chk("b_blk1", 32'(ipu_int), 0);
        tick(); mid(); chk("b_blk2", 32'(ipu_int), 0);
        tick(); jorb = 0;
        mid();
        chk("b_fire", 32'(ipu_int), 1);
        chk("b_id_hold", 32'(int_id), 2);
        tick(); tick();
        rti = 1; tick(); rti = 0; tick();

        // overrun with masked source 0
        do_reset();
        base = n_pulse;
        irq_en = 4'b1110;
        irq = 4'b0001; tick(); irq = 4'b0000; tick();
        irq = 4'b0001; tick(); irq = 4'b0000; tick(); tick();
        mid();
        chk("o_pend", 32'(pending), 4'b0001);
        chk("o_ovr", 32'(overrun), 4'b0001);
        chk("o_noint", 32'(n_pulse - base), 0);
        clr_ovr = 1; tick(); clr_ovr = 0; mid();
        chk("o_ovr_clr", 32'(overrun), 0);
        chk("o_pend_keep", 32'(pending), 4'b0001);

        // missing ack on source 1
        do_reset();
        irq_en = 4'b1111;
        ack_kill = 1;
        irq = 4'b0010; tick(); irq = 4'b0000;
        tick(); mid();
        chk("m_fire1", 32'(ipu_int), 1);
        tick(); tick(); mid();
        chk("m_pend", 32'(pending), 4'b0010);
        chk("m_insv", 32'(in_service), 0);
        chk("m_noint", 32'(ipu_int), 0);
        ack_kill = 0;
        tick(); mid();
        chk("m_refire", 32'(ipu_int), 1);
        chk("m_id", 32'(int_id), 1);
        tick(); tick(); mid();
        chk("m_insv_srv", 32'(in_service), 1);
        rti = 1; tick(); rti = 0; tick();

        // reset while in service with source 2 pending
        irq = 4'b0001; tick(); irq = 4'b0000;
        tick(); tick(); tick();
        irq = 4'b0100; tick(); irq = 4'b0000; mid();
        chk("r_pend_pre", 32'(pending), 4'b0100);
        chk("r_insv_pre", 32'(in_service), 1);
        rst = 1; tick(); rst = 0; mid();
        chk("r_int",  32'(ipu_int), 0);
        chk("r_id",   32'(int_id), 0);
        chk("r_insv", 32'(in_service), 0);
        chk("r_pend", 32'(pending), 0);
        chk("r_ovr",  32'(overrun), 0);
        base = n_pulse;
        rti = 1; tick(); rti = 0; tick(); tick(); mid();
        chk("r_rti_insv", 32'(in_service), 0);
        chk("r_rti_pulses", 32'(n_pulse - base), 0);

        // irq already high as reset releases counts as an edge
        irq = 4'b1000; rst = 1; tick(); tick(); rst = 0;
        tick(); mid();
        chk("e_pend", 32'(pending), 4'b1000);
        tick(); mid();
        chk("e_fire", 32'(ipu_int), 1);
        chk("e_id", 32'(int_id), 3);
        irq = 4'b0000;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected done by 200000");
        $fatal(1);
    end

endmodule
